// File: rtl/sort4_pkg.sv
// Shared types and defaults for the sort4 controller slice.
package sort4_pkg;
  localparam int unsigned SORT4_WIDTH = 4;
  localparam int unsigned SORT4_DEPTH = 4;
  localparam int unsigned SORT4_IDX_W = $clog2(SORT4_DEPTH);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;
endpackage

// File: rtl/sort4_mag_cmp.sv
// Combinational unsigned magnitude comparator (equal / greater / lesser).
module mag_cmp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);
  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

// File: rtl/sort4_ctrl.sv
// In-place bubble-sort controller sharing one mag_cmp across a small register file.
// Optional build macro SORT4_EARLY_EXIT_EN: stop sorting after a pass with no swaps.
module sort4_ctrl
  import sort4_pkg::*;
#(
  parameter int unsigned WIDTH = SORT4_WIDTH,
  parameter int unsigned DEPTH = SORT4_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int unsigned IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LASTJ = IW'(DEPTH - 2);

  state_t state, state_nx;

  logic [WIDTH-1:0] r [DEPTH];
  logic [IW-1:0]    cnt, j, pass, k, jn;
  logic [WIDTH-1:0] op_a, op_b;
  logic             gt;
  logic [1:0]       cmp_unused;
  logic             in_acc, out_acc, swap_en, pass_end, done;

  assign jn       = j + IW'(1);
  assign op_a     = r[j];
  assign op_b     = r[jn];
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;
  assign swap_en  = (state == SORT) && gt;
  assign pass_end = (state == SORT) && (j == LASTJ);

  mag_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a  (op_a),
    .b  (op_b),
    .eq (cmp_unused[0]),
    .gt (gt),
    .lt (cmp_unused[1])
  );

`ifdef SORT4_EARLY_EXIT_EN
  logic swapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             swapped <= 1'b0;
    else if ((state != SORT) || pass_end)   swapped <= 1'b0;
    else if (swap_en)                       swapped <= 1'b1;
  end

  // The swap of the closing compare itself counts toward the pass.
  assign done = pass_end && ((pass == LASTJ) || !(swapped || swap_en));
`else
  assign done = pass_end && (pass == LASTJ);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (in_acc && (cnt == LAST))  state_nx = SORT;
      SORT:    if (done)                     state_nx = DRAIN;
      DRAIN:   if (out_acc && (k == LAST))   state_nx = LOAD;
      default:                               state_nx = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    busy      = (state != LOAD);
    out_data  = (state == DRAIN) ? r[k] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r[i] <= '0;
      cnt  <= '0;
      j    <= '0;
      pass <= '0;
      k    <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_acc) begin
            r[cnt] <= in_data;
            if (cnt == LAST) begin
              cnt  <= '0;
              j    <= '0;
              pass <= '0;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end
        SORT: begin
          if (swap_en) begin
            r[j]  <= r[jn];
            r[jn] <= r[j];
          end
          if (pass_end) begin
            j    <= '0;
            pass <= pass + IW'(1);
          end else begin
            j <= jn;
          end
          if (done) k <= '0;
        end
        DRAIN: begin
          if (out_acc) begin
            if (k == LAST) begin
              k   <= '0;
              cnt <= '0;
            end else begin
              k <= k + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sort4_ctrl.sv
// Table-driven scoreboard bench for sort4_ctrl (both SORT4_EARLY_EXIT_EN builds).
module tb_sort4_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [3:0]  sb [$];

  typedef struct {
    logic [3:0]  din  [4];
    logic [3:0]  dout [4];
    int unsigned lat_early;
    int unsigned swaps;
    bit          stall;
  } vec_t;

  vec_t vecs [7];

  sort4_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_batch(input int v);
    int unsigned lat, sw, beats, guard, stalled, exp_lat;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[v].din[i];
      sb.push_back(vecs[v].dout[i]);
      @(negedge clk);
      chk("load_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("sort_busy", busy, 1);
    chk("sort_in_ready", in_ready, 0);

`ifdef SORT4_EARLY_EXIT_EN
    exp_lat = vecs[v].lat_early;
`else
    exp_lat = 9;
`endif
    lat = 0;
    sw  = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      if (dut.swap_en) sw++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("sort_latency", lat, exp_lat);
    chk("swap_count", sw, vecs[v].swaps);

    out_ready = 1'b1;
    beats     = 0;
    guard     = 0;
    stalled   = 0;
    while (beats < 4 && guard < 100) begin
      @(negedge clk);
      if (!out_valid) begin
        chk("drain_out_valid", 0, 1);
      end else if (out_ready) begin
        if (sb.size() > 0) chk("out_data", out_data, sb.pop_front());
        else               chk("extra_beat", 1, 0);
        beats++;
      end else if (sb.size() > 0) begin
        chk("hold_out_data", out_data, sb[0]);
      end
      @(posedge clk);
      #1;
      guard++;
      if (vecs[v].stall && beats == 1 && stalled < 5) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
    end
    chk("drain_beats", beats, 4);
    chk("scoreboard_empty", sb.size(), 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_out_valid", out_valid, 0);
  endtask

  initial begin
    vecs[0] = '{din: '{4'd5, 4'd2, 4'd9, 4'd1},    dout: '{4'd1, 4'd2, 4'd5, 4'd9},
                lat_early: 9, swaps: 4, stall: 1'b0};
    vecs[1] = '{din: '{4'd3, 4'd3, 4'd0, 4'd3},    dout: '{4'd0, 4'd3, 4'd3, 4'd3},
                lat_early: 9, swaps: 2, stall: 1'b0};
    vecs[2] = '{din: '{4'd1, 4'd2, 4'd3, 4'd4},    dout: '{4'd1, 4'd2, 4'd3, 4'd4},
                lat_early: 3, swaps: 0, stall: 1'b0};
    vecs[3] = '{din: '{4'd15, 4'd14, 4'd13, 4'd12}, dout: '{4'd12, 4'd13, 4'd14, 4'd15},
                lat_early: 9, swaps: 6, stall: 1'b0};
    vecs[4] = '{din: '{4'd8, 4'd6, 4'd4, 4'd2},    dout: '{4'd2, 4'd4, 4'd6, 4'd8},
                lat_early: 9, swaps: 6, stall: 1'b1};
    vecs[5] = '{din: '{4'd15, 4'd0, 4'd7, 4'd8},   dout: '{4'd0, 4'd7, 4'd8, 4'd15},
                lat_early: 6, swaps: 3, stall: 1'b0};
    vecs[6] = '{din: '{4'd4, 4'd3, 4'd2, 4'd1},    dout: '{4'd1, 4'd2, 4'd3, 4'd4},
                lat_early: 9, swaps: 6, stall: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_batch(v);

    // Mid-SORT reset: load 15,0,7,8 then abort it.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[5].din[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midsort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_in_ready", in_ready, 1);
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_out_data", out_data, 0);
    chk("async_reset_busy", busy, 0);
    in_valid = 1'b1;
    in_data  = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset_busy", busy, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    sb.delete();
    run_batch(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
